// File: rtl/vram_pkg.sv
// vram_pkg: shared widths and CPU-side FSM encoding
// for the video-RAM port arbiter.
package vram_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;

    typedef enum logic [2:0] {
        CPU_IDLE = 3'd0,
        CPU_PEND = 3'd1,
        CPU_RD1  = 3'd2,
        CPU_RD2  = 3'd3,
        CPU_DONE = 3'd4
    } cpu_st_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: display fetch, CPU handshake and RAM port bundle.
// slave = arbiter side, master = display/CPU/RAM environment side.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          VID_RD;
    logic [AW-1:0] VID_DA;
    logic [DW-1:0] VID_DD;

    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_A;
    logic [DW-1:0] CPU_DO;
    logic [DW-1:0] CPU_DI;
    logic          CPU_ACK;

    logic [AW-1:0] RAM_A;
    logic          RAM_WE;
    logic [DW-1:0] RAM_D;
    logic [DW-1:0] RAM_Q;

    modport slave (
        input  VID_RD, VID_DA, CPU_REQ, CPU_WE, CPU_A, CPU_DO, RAM_Q,
        output VID_DD, CPU_DI, CPU_ACK, RAM_A, RAM_WE, RAM_D
    );

    modport master (
        output VID_RD, VID_DA, CPU_REQ, CPU_WE, CPU_A, CPU_DO, RAM_Q,
        input  VID_DD, CPU_DI, CPU_ACK, RAM_A, RAM_WE, RAM_D
    );

endinterface

// File: rtl/vram_wbuf.sv
// vram_wbuf: one-entry posted CPU write buffer with
// address compare so reads of the pending address can be forwarded.
module vram_wbuf
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          drain_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    output logic          full_o,
    output logic          hit_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);

    logic          full_q, full_d;
    logic [AW-1:0] a_q, a_d;
    logic [DW-1:0] d_q, d_d;

    always_comb begin
        full_d = full_q;
        a_d    = a_q;
        d_d    = d_q;
        if (load_i) begin
            full_d = 1'b1;
            a_d    = addr_i;
            d_d    = data_i;
        end else if (drain_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            full_q <= 1'b0;
            a_q    <= '0;
            d_q    <= '0;
        end else begin
            full_q <= full_d;
            a_q    <= a_d;
            d_q    <= d_d;
        end
    end

    assign full_o = full_q;
    assign hit_o  = full_q && (a_q == addr_i);
    assign addr_o = a_q;
    assign data_o = d_q;

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: video fetches always own the RAM slot; CPU accesses fill idle slots.
// Define VRAM_WRITE_BUFFER_EN to add a one-entry posted write buffer (vram_wbuf).
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic           PIX_CLK,
    input logic           RESET,
    vram_arbiter_if.slave bus
);

    cpu_st_e       st_q, st_d;
    logic [AW-1:0] ca_q, ca_d;
    logic [DW-1:0] cd_q, cd_d;
    logic          cwe_q, cwe_d;
    logic [AW-1:0] ram_a_q, ram_a_d;
    logic          ram_we_q, ram_we_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic [1:0]    vld_q, vld_d;
    logic [DW-1:0] vid_dd_q, vid_dd_d;
    logic [DW-1:0] cpu_di_q, cpu_di_d;

    logic          wb_full, wb_hit, wb_load, wb_drain;
    logic [AW-1:0] wb_a;
    logic [DW-1:0] wb_d;
    logic          cpu_slot;

`ifdef VRAM_WRITE_BUFFER_EN
    localparam bit WBUF_EN = 1'b1;

    vram_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
        .clk_i   (PIX_CLK),
        .rst_i   (RESET),
        .load_i  (wb_load),
        .drain_i (wb_drain),
        .addr_i  (ca_q),
        .data_i  (cd_q),
        .full_o  (wb_full),
        .hit_o   (wb_hit),
        .addr_o  (wb_a),
        .data_o  (wb_d)
    );
`else
    localparam bit WBUF_EN = 1'b0;

    logic unused_wb;
    assign unused_wb = wb_load | wb_drain;
    assign wb_full   = 1'b0;
    assign wb_hit    = 1'b0;
    assign wb_a      = '0;
    assign wb_d      = '0;
`endif

    // Buffered writes never need a RAM slot of their own from PEND.
    assign cpu_slot = (st_q == CPU_PEND) && !bus.VID_RD && !wb_full
                   && !(WBUF_EN && cwe_q);

    always_comb begin
        ram_a_d  = ram_a_q;
        ram_we_d = 1'b0;
        ram_d_d  = ram_d_q;
        vld_d    = {vld_q[0], 1'b0};
        vid_dd_d = vld_q[1] ? bus.RAM_Q : vid_dd_q;
        wb_drain = 1'b0;
        if (bus.VID_RD) begin
            ram_a_d  = bus.VID_DA;
            vld_d[0] = 1'b1;
        end else if (wb_full) begin
            ram_a_d  = wb_a;
            ram_we_d = 1'b1;
            ram_d_d  = wb_d;
            wb_drain = 1'b1;
        end else if (cpu_slot) begin
            ram_a_d  = ca_q;
            ram_we_d = cwe_q;
            if (cwe_q) ram_d_d = cd_q;
        end
    end

    always_comb begin
        st_d     = st_q;
        ca_d     = ca_q;
        cd_d     = cd_q;
        cwe_d    = cwe_q;
        cpu_di_d = cpu_di_q;
        wb_load  = 1'b0;
        unique case (st_q)
            CPU_IDLE: begin
                if (bus.CPU_REQ) begin
                    st_d  = CPU_PEND;
                    ca_d  = bus.CPU_A;
                    cd_d  = bus.CPU_DO;
                    cwe_d = bus.CPU_WE;
                end
            end
            CPU_PEND: begin
                if (WBUF_EN && cwe_q) begin
                    if (!wb_full) begin
                        wb_load = 1'b1;
                        st_d    = CPU_DONE;
                    end
                end else if (!cwe_q && wb_hit) begin
                    cpu_di_d = wb_d;
                    st_d     = CPU_DONE;
                end else if (cpu_slot) begin
                    st_d = cwe_q ? CPU_DONE : CPU_RD1;
                end
            end
            CPU_RD1: st_d = CPU_RD2;
            CPU_RD2: begin
                cpu_di_d = bus.RAM_Q;
                st_d     = CPU_DONE;
            end
            CPU_DONE: st_d = CPU_IDLE;
            default:  st_d = CPU_IDLE;
        endcase
    end

    always_ff @(posedge PIX_CLK or posedge RESET) begin
        if (RESET) begin
            st_q     <= CPU_IDLE;
            ca_q     <= '0;
            cd_q     <= '0;
            cwe_q    <= 1'b0;
            ram_a_q  <= '0;
            ram_we_q <= 1'b0;
            ram_d_q  <= '0;
            vld_q    <= '0;
            vid_dd_q <= '0;
            cpu_di_q <= '0;
        end else begin
            st_q     <= st_d;
            ca_q     <= ca_d;
            cd_q     <= cd_d;
            cwe_q    <= cwe_d;
            ram_a_q  <= ram_a_d;
            ram_we_q <= ram_we_d;
            ram_d_q  <= ram_d_d;
            vld_q    <= vld_d;
            vid_dd_q <= vid_dd_d;
            cpu_di_q <= cpu_di_d;
        end
    end

    assign bus.VID_DD  = vid_dd_q;
    assign bus.CPU_DI  = cpu_di_q;
    assign bus.CPU_ACK = (st_q == CPU_DONE);
    assign bus.RAM_A   = ram_a_q;
    assign bus.RAM_WE  = ram_we_q;
    assign bus.RAM_D   = ram_d_q;

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shared video-RAM port arbiter sitting directly upstream of the MC6847 VGA display stage. It multiplexes the display's strobed character/graphics fetches (RD/DA/DD) and the Z80-side CPU accesses onto one single-port synchronous 8 KB RAM. Video fetches always win the RAM slot, so display latency is fixed. CPU accesses use a request/acknowledge handshake and are stalled into free slots.

## Interface
Parameters:
- AW, 13, RAM address width (8 KB)
- DW, 8, data width

Ports:
- PIX_CLK  in  1  pixel clock; sole clock
- RESET  in  1  asynchronous, active-high reset
- VID_RD  in  1  display fetch strobe, sampled each PIX_CLK edge
- VID_DA  in  AW  display fetch address, valid with VID_RD
- VID_DD  out  DW  fetched display byte, registered
- CPU_REQ  in  1  CPU access request; held high until CPU_ACK
- CPU_WE  in  1  1 = write, 0 = read; stable while CPU_REQ high
- CPU_A  in  AW  CPU address; stable while CPU_REQ high
- CPU_DO  in  DW  CPU write data
- CPU_DI  out  DW  CPU read data; valid in the CPU_ACK cycle, held afterwards
- CPU_ACK  out  1  one-cycle completion pulse
- RAM_A  out  AW  registered RAM address
- RAM_WE  out  1  registered RAM write enable
- RAM_D  out  DW  registered RAM write data
- RAM_Q  in  DW  RAM read data, valid the cycle after RAM_A is applied

## Operation
- Slot rule, evaluated each cycle: if VID_RD=1, the next RAM cycle belongs to video (RAM_A<=VID_DA, RAM_WE<=0). Otherwise it goes to the write buffer if full, else to the CPU FSM if it is in PEND. Otherwise RAM_WE<=0 and RAM_A holds.
- Video pipeline: 2-bit valid shift register tracks video slots. VID_DD<=RAM_Q when the slot issued two cycles earlier was a video slot. Otherwise VID_DD holds.
- CPU FSM states: IDLE, PEND, RD1, RD2, ACK.
  - IDLE→PEND on CPU_REQ. Address, data and WE are latched on entry.
  - PEND: waits for a free slot, then issues. Writes go to ACK; reads go to RD1.
  - RD1→RD2 unconditionally. RD2 captures RAM_Q into CPU_DI, then goes to ACK.
  - ACK: asserts CPU_ACK for exactly one cycle, then returns to IDLE. CPU_REQ is ignored in the ACK cycle.
- CPU writes never share a cycle with a video slot. VID_RD=1 continuously stalls the CPU indefinitely. This is by design; there is no starvation guard.
- Reset values: VID_DD=0, CPU_DI=0, CPU_ACK=0, RAM_A=0, RAM_WE=0, RAM_D=0. FSM goes to IDLE, write buffer is empty, video valid pipe is cleared.
- Reset mid-transaction: the transaction is dropped with no ACK and no partial write. The CPU must re-request.

## Timing
- Video: VID_RD sampled at edge N → RAM_A driven after N+1 → VID_DD updated at edge N+3. Fixed latency is 3 cycles for every video fetch, including back-to-back fetches (throughput 1/cycle).
- CPU read, uncontended: REQ sampled at edge N → PEND → issue → ACK high after edge N+4. Minimum read latency is 4 cycles.
- CPU write, uncontended: ACK high after edge N+2.
- Each cycle of VID_RD=1 while in PEND adds exactly one cycle.
- VID_RD and CPU_REQ rising in the same cycle: video takes the slot, and the CPU issues in the first cycle with VID_RD=0.

## Configuration
- VRAM_WRITE_BUFFER_EN defined: adds a one-entry posted write buffer (address, data, full flag).
  - CPU write in IDLE with the buffer empty: loads the buffer and goes directly to ACK (ACK at N+2 regardless of video contention).
  - Buffer drains into the first slot not used by video.
  - CPU write with the buffer full: waits in PEND until the buffer drains.
  - CPU read with the buffer full and the same address: forwards the buffer data and goes to ACK with no RAM access.
  - CPU read with the buffer full and a different address: waits until the buffer drains, preserving ordering.
- VRAM_WRITE_BUFFER_EN undefined: no buffer. Writes complete only after their RAM slot issues.

## Structure
- Shared package (vram_pkg): AW/DW defaults and the CPU FSM state encoding (3-bit enum IDLE/PEND/RD1/RD2/ACK).
- One sub-module: vram_wbuf (posted write buffer with address-compare forward), instantiated only under VRAM_WRITE_BUFFER_EN.
- RAM is external to this block.

## Test plan
- RAM preloaded with 0x1000=0x5A. VID_RD pulse at 0x1000, edge 10 → VID_DD=0x5A from edge 13. CPU_ACK stays 0.
- VID_RD held for 8 cycles, addresses 0x0000–0x0007 holding 0x00–0x07 → VID_DD steps 0x00..0x07 on consecutive edges starting 3 after the first.
- CPU read of 0x0123=0xC3 with VID_RD high for 5 cycles → ACK exactly 5 cycles later than uncontended (N+9), CPU_DI=0xC3. Video data is uncorrupted.
- CPU write 0x0200=0xA5 then CPU read 0x0200 → CPU_DI=0xA5.
  - With buffer: the read ACKs without RAM_WE toggling a second time.
  - Without buffer: RAM_WE pulses once, before the read slot.
- RESET asserted in RD1 → all outputs 0 immediately, no CPU_ACK, no RAM_WE. After release, a new request completes normally.
- With the buffer under VID_RD held high: write ACK at N+2. RAM_WE stays 0 until VID_RD drops, then pulses once with the correct address and data.
